// File: rtl/fp8_special_resolver.sv
// Two-stage FP8 special-case resolver: S1 classifies operands, S2 decides whether the
// result is fully determined by special values. Optional sticky flags: FP8_STICKY_FLAGS_EN.
module fp8_special_resolver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] fp_operation,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       result_is_special,
  output logic       exc_invalid,
  input  logic       flag_clr,
  output logic       sticky_invalid,
  output logic [7:0] invalid_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [7:0] CANON_NAN = 8'h7C;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp8_class_t;

  function automatic fp8_class_t classify(input logic [7:0] x);
    fp8_class_t c;
    c.sign = x[7];
    c.zero = (x[6:0] == 7'h00);
    c.inf  = (x[6:3] == 4'hF) && (x[2:0] == 3'b000);
    c.nan  = (x[6:3] == 4'hF) && (x[2:0] != 3'b000);
    return c;
  endfunction

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // in_ready never depends on in_valid; out_valid never depends on out_ready, and the
  // output payload holds while out_valid is high and out_ready is low.
  logic       v1;
  logic       v2;
  logic       adv;
  logic       in_fire;
  logic       out_fire;

  logic [1:0] s1_op;
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  fp8_class_t s1_ca;
  fp8_class_t s1_cb;

  logic [7:0] b_eff;
  fp8_class_t ca_d;
  fp8_class_t cb_d;

  logic [7:0] res_d;
  logic       spec_d;
  logic       inv_d;
  logic       any_nan;
  logic       sign_xor;

  assign adv      = !v2 || out_ready;
  assign in_ready = !v1 || adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = v2 && out_ready;
  assign out_valid = v2;

  // Subtraction becomes addition of the negated B; NaN payloads pass untouched.
  always_comb begin
    b_eff = op_b;
    if (fp_operation == OP_SUB && !classify(op_b).nan) begin
      b_eff = {~op_b[7], op_b[6:0]};
    end
    ca_d = classify(op_a);
    cb_d = classify(b_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      s1_op <= 2'b00;
      s1_a  <= 8'h00;
      s1_b  <= 8'h00;
      s1_ca <= '0;
      s1_cb <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_op <= fp_operation;
        s1_a  <= op_a;
        s1_b  <= b_eff;
        s1_ca <= ca_d;
        s1_cb <= cb_d;
      end
    end
  end

  assign any_nan  = s1_ca.nan || s1_cb.nan;
  assign sign_xor = s1_ca.sign ^ s1_cb.sign;

  always_comb begin
    res_d  = 8'h00;
    spec_d = 1'b0;
    inv_d  = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: begin
        if (any_nan || (s1_ca.inf && s1_cb.inf && sign_xor)) begin
          res_d  = CANON_NAN;
          spec_d = 1'b1;
          inv_d  = 1'b1;
        end else if (s1_ca.inf) begin
          res_d  = s1_a;
          spec_d = 1'b1;
        end else if (s1_cb.inf) begin
          res_d  = s1_b;
          spec_d = 1'b1;
        end else if (s1_ca.zero && s1_cb.zero) begin
          res_d  = {s1_ca.sign && s1_cb.sign, 7'h00};
          spec_d = 1'b1;
        end else if (s1_ca.zero) begin
          res_d  = s1_b;
          spec_d = 1'b1;
        end else if (s1_cb.zero) begin
          res_d  = s1_a;
          spec_d = 1'b1;
        end
      end
      OP_MUL: begin
        if (any_nan || (s1_ca.zero && s1_cb.inf) || (s1_ca.inf && s1_cb.zero)) begin
          res_d  = CANON_NAN;
          spec_d = 1'b1;
          inv_d  = 1'b1;
        end else if (s1_ca.inf || s1_cb.inf) begin
          res_d  = {sign_xor, 7'h78};
          spec_d = 1'b1;
        end else if (s1_ca.zero || s1_cb.zero) begin
          res_d  = {sign_xor, 7'h00};
          spec_d = 1'b1;
        end
      end
      default: begin
        res_d  = CANON_NAN;
        spec_d = 1'b1;
        inv_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2                <= 1'b0;
      result            <= 8'h00;
      result_is_special <= 1'b0;
      exc_invalid       <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        result            <= res_d;
        result_is_special <= spec_d;
        exc_invalid       <= inv_d;
      end
    end
  end

`ifdef FP8_STICKY_FLAGS_EN
  logic inv_event;
  assign inv_event = out_fire && exc_invalid;

  // A clear coinciding with an invalid event leaves exactly that one event recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid <= 1'b0;
      invalid_count  <= 8'h00;
    end else if (flag_clr) begin
      sticky_invalid <= inv_event;
      invalid_count  <= {7'h00, inv_event};
    end else if (inv_event) begin
      sticky_invalid <= 1'b1;
      if (invalid_count != 8'hFF) begin
        invalid_count <= invalid_count + 8'h01;
      end
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = flag_clr ^ out_fire;
  assign sticky_invalid     = 1'b0;
  assign invalid_count      = 8'h00;
`endif

endmodule

// File: doc/fp8_special_resolver.md
FP8_SPECIAL_RESOLVER -- requirements
Module: fp8_special_resolver

Interface
REQ-001 SHALL have ports: CLK in 1, rising-edge clock; RST_N in 1, asynchronous active-low reset.
REQ-002 SHALL have IN_VALID in 1, IN_READY out 1: input handshake; transfer when both high at a CLK edge.
REQ-003 SHALL have FP_OPERATION in 2: 00 ADD, 01 SUB, 10 MUL, 11 reserved; OP_A, OP_B in 8 each: FP8 operands.
REQ-004 SHALL have OUT_VALID out 1, OUT_READY in 1: output handshake; transfer when both high.
REQ-005 SHALL have RESULT out 8; RESULT_IS_SPECIAL out 1 (1 = RESULT is final, 0 = arithmetic datapath required); EXC_INVALID out 1.
REQ-006 SHALL have FLAG_CLR in 1, STICKY_INVALID out 1, INVALID_COUNT out 8 (see Configuration).

Function
REQ-007 FP8 format SHALL be sign[7], exponent[6:3], mantissa[2:0]; exponent 1111 with mantissa 000 = inf (+inf 8'h78, -inf 8'hF8); exponent 1111 with mantissa nonzero = NaN; 8'h00 / 8'h80 = +0 / -0; canonical NaN 8'h7C.
REQ-008 Pipeline SHALL be two stages (S1 classify, S2 resolve) with valid bits V1, V2; latency from input transfer to OUT_VALID = 2 cycles when not stalled.
REQ-009 Definitions: ADV = !V2 || OUT_READY; IN_READY = !V1 || ADV; S1 contents SHALL move to S2 when ADV; V2 cleared on output transfer with no S1 data.
REQ-010 While OUT_VALID && !OUT_READY, RESULT, RESULT_IS_SPECIAL, EXC_INVALID SHALL hold stable; no data loss or duplication at full throughput (one transfer per cycle).
REQ-011 SUB SHALL be resolved as ADD with OP_B sign bit inverted (NaN operands unaffected).
REQ-012 ADD: any NaN, or opposite-sign infs -> 8'h7C, special, invalid; one inf or same-sign infs -> that inf, special; both zero -> 8'h80 only if both -0, else 8'h00, special; one zero, other finite nonzero -> other operand, special.
REQ-013 MUL: any NaN, or zero x inf -> 8'h7C, special, invalid; inf x nonzero -> inf with sign A^B, special; zero x finite -> zero with sign A^B, special.
REQ-014 Reserved op 11 SHALL yield 8'h7C, special, invalid regardless of operands.
REQ-015 All other cases SHALL yield RESULT 8'h00, RESULT_IS_SPECIAL 0, EXC_INVALID 0.
REQ-016 Invalid event SHALL be an output transfer with EXC_INVALID=1; it SHALL set STICKY_INVALID and increment INVALID_COUNT, saturating at 8'hFF.
REQ-017 FLAG_CLR SHALL zero STICKY_INVALID and INVALID_COUNT next edge; if an invalid event coincides, result SHALL be STICKY_INVALID=1, INVALID_COUNT=1.

Reset
REQ-018 RST_N low SHALL asynchronously clear V1, V2, OUT_VALID, RESULT (8'h00), RESULT_IS_SPECIAL, EXC_INVALID, STICKY_INVALID, INVALID_COUNT; IN_READY SHALL read 1 during and after reset.
REQ-019 Reset mid-operation SHALL discard all in-flight entries; no output transfer follows for them.

Configuration
REQ-020 Macro FP8_STICKY_FLAGS_EN defined: REQ-016/017 sticky flag and counter logic present.
REQ-021 FP8_STICKY_FLAGS_EN undefined: STICKY_INVALID and INVALID_COUNT SHALL be constant 0, FLAG_CLR ignored, no registers for them; all other behaviour identical.

Verification
REQ-022 ADD 8'h78 + 8'hF8, OUT_READY=1 -> two cycles later RESULT 8'h7C, special 1, invalid 1, INVALID_COUNT 1.
REQ-023 SUB 8'hF8 - 8'h78 -> RESULT 8'hF8, special 1, invalid 0; MUL 8'h80 x 8'h38 -> RESULT 8'h80, special 1; ADD 8'h38 + 8'h40 -> special 0.
REQ-024 Back-to-back 4 inputs with OUT_READY low for 3 cycles after first OUT_VALID -> IN_READY drops after 2 accepted, outputs in order, stalled values stable, none lost.
REQ-025 300 consecutive MUL 8'h00 x 8'h78 -> INVALID_COUNT saturates at 8'hFF; FLAG_CLR coincident with next invalid -> count 1, sticky 1.
REQ-026 Assert RST_N low asynchronously mid-stream with V1=V2=1 -> outputs zero immediately, no stale output after release.
REQ-027 Build without FP8_STICKY_FLAGS_EN, rerun REQ-022 -> STICKY_INVALID 0, INVALID_COUNT 0, RESULT unchanged.
